// File: rtl/led_pio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_pio_pkg
//  Description : Shared constants for the Avalon-MM LED / GPO port:
//                register word addresses and PWM duty register layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_pio_pkg;

  // Word addresses of the slave register map
  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] ADDR_MASK   = 3'd3;
  localparam logic [2:0] ADDR_PERIOD = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;
  localparam logic [2:0] ADDR_DUTY   = 3'd6;

  // PWM duty register (only present when LED_PIO_PWM_EN is defined)
  localparam int                DUTY_W     = 8;
  localparam logic [DUTY_W-1:0] DUTY_RESET = 8'hFF;

endpackage : led_pio_pkg
`default_nettype wire

// File: rtl/led_pio_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : led_pio_prescaler
//  Description : Blink prescaler. Counts down from the programmed period and
//                toggles the blink phase every (period + 1) cycles. A period
//                of zero freezes counter and phase.
//  Ports       : clk       - system clock
//                reset_n   - asynchronous active-low reset
//                period_i  - period value (also the load value when load_i)
//                load_i    - restart: cnt <= period_i, phase <= 0
//                phase_o   - current blink phase
//                cnt_o     - current down-counter value
//  Revision    : 1.0 - initial release
// ============================================================================
module led_pio_prescaler #(
  parameter int                    PRESCALE_W   = 24,
  parameter logic [PRESCALE_W-1:0] RESET_PERIOD = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [PRESCALE_W-1:0] period_i,
  input  logic                  load_i,
  output logic                  phase_o,
  output logic [PRESCALE_W-1:0] cnt_o
);

  logic [PRESCALE_W-1:0] cnt_q;
  logic                  phase_q;

  // A load wins over an expiry in the same cycle: the reload/toggle that
  // would have happened is simply discarded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= RESET_PERIOD;
      phase_q <= 1'b0;
    end else if (load_i) begin
      cnt_q   <= period_i;
      phase_q <= 1'b0;
    end else if (period_i != '0) begin
      if (cnt_q == '0) begin
        cnt_q   <= period_i;
        phase_q <= ~phase_q;
      end else begin
        cnt_q   <= cnt_q - 1'b1;
      end
    end
  end

  assign phase_o = phase_q;
  assign cnt_o   = cnt_q;

endmodule : led_pio_prescaler
`default_nettype wire

// File: rtl/avalon_led_pio.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_led_pio
//  Description : Zero-wait-state Avalon-MM slave driving board LEDs / GPOs.
//                Data register with atomic SET/CLEAR aliases, per-bit blink
//                mask and a programmable blink prescaler. Optional 8-bit PWM
//                dimming is compiled in with the macro LED_PIO_PWM_EN.
//  Ports       : clk, reset_n  - clock, asynchronous active-low reset
//                address       - word register select (3 bits)
//                chipselect    - slave select
//                write_n       - active-low write strobe
//                writedata     - 32-bit write data
//                readdata      - 32-bit combinational read data
//                out_port      - DATA_W driven outputs
//                blink_phase   - current blink phase
//  Revision    : 1.0 - initial release
// ============================================================================
module avalon_led_pio
  import led_pio_pkg::*;
#(
  parameter int                    DATA_W       = 10,
  parameter int                    PRESCALE_W   = 24,
  parameter logic [DATA_W-1:0]     RESET_VALUE  = '0,
  parameter logic [PRESCALE_W-1:0] RESET_PERIOD = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_port,
  output logic              blink_phase
);

  logic [DATA_W-1:0]     data_q,   data_d;
  logic [DATA_W-1:0]     mask_q,   mask_d;
  logic [PRESCALE_W-1:0] period_q, period_d;

  logic                  w_wr;
  logic                  w_load;
  logic                  w_phase;
  logic [PRESCALE_W-1:0] w_cnt;
  logic [DATA_W-1:0]     w_blink;
  logic                  w_unused;

  assign w_wr = chipselect && !write_n;

  // --------------------------------------------------------------------------
  // Register write decode
  // --------------------------------------------------------------------------
  always_comb begin
    data_d   = data_q;
    mask_d   = mask_q;
    period_d = period_q;
    w_load   = 1'b0;
    if (w_wr) begin
      case (address)
        ADDR_DATA:   data_d   = writedata[DATA_W-1:0];
        ADDR_SET:    data_d   = data_q | writedata[DATA_W-1:0];
        ADDR_CLEAR:  data_d   = data_q & ~writedata[DATA_W-1:0];
        ADDR_MASK:   mask_d   = writedata[DATA_W-1:0];
        ADDR_PERIOD: begin
          period_d = writedata[PRESCALE_W-1:0];
          w_load   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= RESET_VALUE;
      mask_q   <= '0;
      period_q <= RESET_PERIOD;
    end else begin
      data_q   <= data_d;
      mask_q   <= mask_d;
      period_q <= period_d;
    end
  end

  // --------------------------------------------------------------------------
  // Blink prescaler. Feeding period_d lets one port carry both the running
  // period and, on a PERIOD write, the freshly written load value.
  // --------------------------------------------------------------------------
  led_pio_prescaler #(
    .PRESCALE_W   (PRESCALE_W),
    .RESET_PERIOD (RESET_PERIOD)
  ) u_prescaler (
    .clk      (clk),
    .reset_n  (reset_n),
    .period_i (period_d),
    .load_i   (w_load),
    .phase_o  (w_phase),
    .cnt_o    (w_cnt)
  );

  assign blink_phase = w_phase;
  assign w_blink     = data_q ^ (mask_q & {DATA_W{w_phase}});

`ifdef LED_PIO_PWM_EN
  // --------------------------------------------------------------------------
  // PWM dimming: free-running 8-bit counter compared against DUTY.
  // DUTY = 8'hFF is special-cased to mean fully on.
  // --------------------------------------------------------------------------
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] pwm_cnt_q;
  logic              w_pwm_on;

  always_comb begin
    duty_d = duty_q;
    if (w_wr && (address == ADDR_DUTY)) begin
      duty_d = writedata[DUTY_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_q    <= DUTY_RESET;
      pwm_cnt_q <= '0;
    end else begin
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
    end
  end

  assign w_pwm_on = (duty_q == DUTY_RESET) || (pwm_cnt_q < duty_q);
  assign out_port = w_blink & {DATA_W{w_pwm_on}};
`else
  assign out_port = w_blink;
`endif

  // --------------------------------------------------------------------------
  // Read mux: combinational, zero-extended, no side effects
  // --------------------------------------------------------------------------
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[DATA_W-1:0]     = data_q;
      ADDR_MASK:   readdata[DATA_W-1:0]     = mask_q;
      ADDR_PERIOD: readdata[PRESCALE_W-1:0] = period_q;
      ADDR_STATUS: readdata[0]              = w_phase;
`ifdef LED_PIO_PWM_EN
      ADDR_DUTY:   readdata[DUTY_W-1:0]     = duty_q;
`endif
      default: ;
    endcase
  end

  // Upper writedata bits and the raw counter value are intentionally unused.
  assign w_unused = ^{writedata, w_cnt};

endmodule : avalon_led_pio
`default_nettype wire

// File: tb/tb_avalon_led_pio.sv
`default_nettype none
// ============================================================================
//  Module      : tb_avalon_led_pio
//  Description : Self-checking bench for avalon_led_pio (DATA_W=10,
//                PRESCALE_W=24, RESET_VALUE=10'h155, RESET_PERIOD=0).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_led_pio;

  localparam int          DW = 10;
  localparam logic [9:0]  RV = 10'h155;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [DW-1:0] out_port;
  logic        blink_phase;

  int checks = 0;
  int errors = 0;

  avalon_led_pio #(
    .DATA_W       (DW),
    .PRESCALE_W   (24),
    .RESET_VALUE  (RV),
    .RESET_PERIOD (24'd0)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .out_port    (out_port),
    .blink_phase (blink_phase)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model: register contents plus edge counts. Blink phase is
  // derived arithmetically from the number of edges since the last PERIOD
  // load: phase = floor(k / (P+1)) mod 2, or 0 when P == 0.
  // --------------------------------------------------------------------------
  logic [9:0]  m_data, m_mask;
  int unsigned m_period, m_k, m_e;
  int unsigned m_duty;

  function automatic void m_reset();
    m_data = RV; m_mask = '0; m_period = 0; m_k = 0; m_e = 0; m_duty = 255;
  endfunction

  function automatic logic m_phase();
    if (m_period == 0) return 1'b0;
    return ((m_k / (m_period + 1)) % 2) == 1;
  endfunction

  function automatic logic [9:0] m_out();
    logic [9:0] b;
    b = m_data ^ (m_mask & {10{m_phase()}});
`ifdef LED_PIO_PWM_EN
    if (!(m_duty == 255 || (m_e % 256) < m_duty)) b = '0;
`endif
    return b;
  endfunction

  function automatic logic [31:0] m_rd(input logic [2:0] a);
    case (a)
      3'd0: return {22'd0, m_data};
      3'd3: return {22'd0, m_mask};
      3'd4: return m_period;
      3'd5: return {31'd0, m_phase()};
`ifdef LED_PIO_PWM_EN
      3'd6: return m_duty;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic void m_edge(input logic cs, input logic wn,
                                 input logic [2:0] a, input logic [31:0] wd);
    logic load;
    load = 1'b0;
    if (cs && !wn) begin
      case (a)
        3'd0: m_data = wd[9:0];
        3'd1: m_data = m_data | wd[9:0];
        3'd2: m_data = m_data & ~wd[9:0];
        3'd3: m_mask = wd[9:0];
        3'd4: begin m_period = wd[23:0]; load = 1'b1; end
`ifdef LED_PIO_PWM_EN
        3'd6: m_duty = wd[7:0];
`endif
        default: ;
      endcase
    end
    if (load) m_k = 0; else m_k = m_k + 1;
    m_e = m_e + 1;
  endfunction

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge; the model sees exactly the inputs present at the edge.
  // Returns 1 time unit after the edge.
  task automatic step();
    logic cs, wn; logic [2:0] a; logic [31:0] wd;
    cs = chipselect; wn = write_n; a = address; wd = writedata;
    @(posedge clk);
    m_edge(cs, wn, a, wd);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    step();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(name, readdata, exp);
  endtask

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [9:0]  exp_out;
    logic [2:0]  rd_addr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[8];
  int   hi_cnt;

  initial begin
    vecs[0] = '{3'd0, 32'h0000_03F0, 10'h3F0, 3'd0, 32'h3F0};
    vecs[1] = '{3'd1, 32'h0000_000F, 10'h3FF, 3'd1, 32'h0};
    vecs[2] = '{3'd2, 32'h0000_0300, 10'h0FF, 3'd2, 32'h0};
    vecs[3] = '{3'd0, 32'hFFFF_FC05, 10'h005, 3'd0, 32'h005};
    vecs[4] = '{3'd3, 32'hFFFF_FC03, 10'h005, 3'd3, 32'h003};
    vecs[5] = '{3'd7, 32'h0000_03FF, 10'h005, 3'd7, 32'h0};
    vecs[6] = '{3'd4, 32'hFF00_0000, 10'h005, 3'd4, 32'h0};
    vecs[7] = '{3'd5, 32'h0000_0001, 10'h005, 3'd5, 32'h0};

    m_reset();

    // ---- Reset state ------------------------------------------------------
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", {22'd0, out_port}, {22'd0, RV});
    chk("reset_phase", {31'd0, blink_phase}, 32'd0);
    #1 reset_n = 1'b1;
    rd_chk("reset_rd_data", 3'd0, 32'h155);
    rd_chk("reset_rd_status", 3'd5, 32'h0);

    // ---- Table-driven register accesses -----------------------------------
    for (int i = 0; i < 8; i++) begin
      wr(vecs[i].addr, vecs[i].wd);
      chk($sformatf("vec%0d_out", i), {22'd0, out_port}, {22'd0, vecs[i].exp_out});
      rd_chk($sformatf("vec%0d_rd", i), vecs[i].rd_addr, vecs[i].exp_rd);
    end

    // ---- Blink at PERIOD=4: toggles every 5 cycles ------------------------
    wr(3'd0, 32'h0);
    wr(3'd3, 32'h3);
    wr(3'd4, 32'h4);
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("blink_out_k%0d", k), {22'd0, out_port},
          ((k / 5) % 2 == 1) ? 32'h3 : 32'h0);
      rd_chk($sformatf("blink_status_k%0d", k), 3'd5, ((k / 5) % 2 == 1) ? 32'h1 : 32'h0);
      step();
    end

    // ---- PERIOD=0 written on an expiry edge (would toggle 0->1) -----------
    wr(3'd4, 32'h4);
    repeat (4) step();
    wr(3'd4, 32'h0);
    for (int k = 0; k < 12; k++) begin
      chk("halt_out", {22'd0, out_port}, 32'h0);
      chk("halt_phase", {31'd0, blink_phase}, 32'h0);
      step();
    end

    // ---- Asynchronous reset mid-blink with phase = 1 ----------------------
    wr(3'd4, 32'h4);
    repeat (6) step();
    chk("preRst_out", {22'd0, out_port}, 32'h3);
    reset_n = 1'b0;
    #1;
    m_reset();
    chk("asyncRst_out", {22'd0, out_port}, {22'd0, RV});
    chk("asyncRst_phase", {31'd0, blink_phase}, 32'h0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    rd_chk("postRst_mask", 3'd3, 32'h0);
    rd_chk("postRst_period", 3'd4, 32'h0);
    rd_chk("postRst_data", 3'd0, 32'h155);

`ifdef LED_PIO_PWM_EN
    // ---- PWM duty cycles --------------------------------------------------
    wr(3'd0, 32'h1);
    rd_chk("duty_reset", 3'd6, 32'hFF);
    wr(3'd6, 32'd64);
    rd_chk("duty_rd", 3'd6, 32'd64);
    hi_cnt = 0;
    for (int i = 0; i < 256; i++) begin step(); if (out_port[0]) hi_cnt++; end
    chk("pwm64_high", hi_cnt, 64);
    wr(3'd6, 32'd255);
    hi_cnt = 0;
    for (int i = 0; i < 256; i++) begin step(); if (out_port[0]) hi_cnt++; end
    chk("pwm255_high", hi_cnt, 256);
    wr(3'd6, 32'd0);
    hi_cnt = 0;
    for (int i = 0; i < 256; i++) begin step(); if (out_port[0]) hi_cnt++; end
    chk("pwm0_high", hi_cnt, 0);
    wr(3'd6, 32'd255);
`else
    // ---- Address 6 is unimplemented ---------------------------------------
    wr(3'd0, 32'h1);
    wr(3'd6, 32'h40);
    rd_chk("addr6_rd", 3'd6, 32'h0);
    chk("addr6_out", {22'd0, out_port}, 32'h1);
`endif

    // ---- Randomized traffic against the reference model -------------------
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] a;
      a = 3'($urandom_range(0, 7));
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 1) == 1);
      address    = a;
      if (a == 3'd4)
        writedata = ($urandom & 32'hFF00_0000) | $urandom_range(0, 6);
      else
        writedata = $urandom;
      step();
      chipselect = 1'b0; write_n = 1'b1;
      chk("rand_out", {22'd0, out_port}, {22'd0, m_out()});
      chk("rand_phase", {31'd0, blink_phase}, {31'd0, m_phase()});
      a = 3'($urandom_range(0, 7));
      rd_chk("rand_rd", a, m_rd(a));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_avalon_led_pio
`default_nettype wire
